// File: rtl/mux_sel_sequencer_pkg.sv
// mux_seq_pkg: shared types and constants for the mux select sequencer.
//   state_e   - sequencer FSM states
//   SEL_W_DEF - default select width
//   N_CH      - channel count implied by SEL_W_DEF
package mux_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDone
  } state_e;

  localparam int unsigned SEL_W_DEF = 3;
  localparam int unsigned N_CH      = 2 ** SEL_W_DEF;

endpackage

// File: rtl/mux_sel_sequencer_if.sv
// mux_sel_sequencer_if: handshake and mux-drive bundle of the sequencer.
//   master modport - the word source, which also observes the sequencer outputs
//   slave modport  - the sequencer itself
// Signals: start_valid/start_ready/data_in/lsb_first handshake, abort,
//          data_q/sel to the 8:1 mux, bit_valid/frame_first/frame_last framing,
//          busy and done status.
interface mux_sel_sequencer_if
  import mux_seq_pkg::*;
#(
  parameter int unsigned SEL_W = SEL_W_DEF
);

  logic             start_valid;
  logic             start_ready;
  logic [7:0]       data_in;
  logic             lsb_first;
  logic             abort;
  logic [7:0]       data_q;
  logic [SEL_W-1:0] sel;
  logic             bit_valid;
  logic             frame_first;
  logic             frame_last;
  logic             busy;
  logic             done;

  modport master (
    output start_valid,
    output data_in,
    output lsb_first,
    output abort,
    input  start_ready,
    input  data_q,
    input  sel,
    input  bit_valid,
    input  frame_first,
    input  frame_last,
    input  busy,
    input  done
  );

  modport slave (
    input  start_valid,
    input  data_in,
    input  lsb_first,
    input  abort,
    output start_ready,
    output data_q,
    output sel,
    output bit_valid,
    output frame_first,
    output frame_last,
    output busy,
    output done
  );

endinterface

// File: rtl/mux_sel_sequencer_dwell_timer.sv
// dwell_timer: reloadable down-counter that marks the end of each dwell period.
//   clk, rst_n - clock and synchronous active-low reset
//   en         - count while high
//   clear      - synchronous reload to DWELL-1 (takes priority over en)
//   tick       - high on the terminal (zero) count while enabled
module dwell_timer #(
  parameter int unsigned DWELL = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clear,
  output logic tick
);

  localparam logic [CNT_W-1:0] Reload = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= Reload;
    end else if (en) begin
      cnt_q <= (cnt_q == '0) ? Reload : cnt_q - CNT_W'(1);
    end
  end

  assign tick = en && (cnt_q == '0);

endmodule

// File: rtl/mux_sel_sequencer.sv
// mux_sel_sequencer: drives an 8:1 bit mux, presenting each bit of a latched
// word for DWELL clocks so the mux output becomes a framed serial stream.
//   clk, rst_n - clock and synchronous active-low reset
//   bus        - slave side of mux_sel_sequencer_if (handshake, abort,
//                data_q/sel to the mux, framing and status)
// All bus outputs are registered except start_ready and busy, which decode
// the state directly.
module mux_sel_sequencer
  import mux_seq_pkg::*;
#(
  parameter int unsigned SEL_W = SEL_W_DEF,
  parameter int unsigned DWELL = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mux_sel_sequencer_if.slave   bus
);

  localparam int unsigned     NCh    = 2 ** SEL_W;
  localparam logic [SEL_W:0]  LastCh = (SEL_W + 1)'(NCh - 1);
  localparam logic [SEL_W-1:0] SelMax = SEL_W'(NCh - 1);

  if (DWELL == 0) begin : g_bad_dwell
    $fatal(1, "mux_sel_sequencer: DWELL must be at least 1");
  end
  if (longint'(DWELL) > (longint'(1) << CNT_W)) begin : g_bad_cnt_w
    $fatal(1, "mux_sel_sequencer: DWELL does not fit in CNT_W bits");
  end

  state_e           state_q;
  logic [7:0]       data_q;
  logic             lsb_q;
  logic [SEL_W:0]   ch_q;
  logic [SEL_W-1:0] sel_q;
  logic             bit_valid_q;
  logic             frame_first_q;
  logic             frame_last_q;
  logic             done_q;

  logic accept;
  logic tick;
  logic [SEL_W:0] ch_next;

  assign accept  = (state_q == StIdle) && bus.start_valid;
  assign ch_next = ch_q + (SEL_W + 1)'(1);

  dwell_timer #(
    .DWELL(DWELL),
    .CNT_W(CNT_W)
  ) u_dwell_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (state_q == StScan),
    .clear(accept),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      data_q        <= '0;
      lsb_q         <= 1'b0;
      ch_q          <= '0;
      sel_q         <= '0;
      bit_valid_q   <= 1'b0;
      frame_first_q <= 1'b0;
      frame_last_q  <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (bus.start_valid) begin
            data_q        <= bus.data_in;
            lsb_q         <= bus.lsb_first;
            sel_q         <= bus.lsb_first ? '0 : SelMax;
            ch_q          <= '0;
            bit_valid_q   <= 1'b1;
            frame_first_q <= 1'b1;
            frame_last_q  <= (LastCh == '0);
            state_q       <= StScan;
          end
        end
        StScan: begin
          if (bus.abort) begin
            // sel and data_q deliberately hold so the mux keeps its last bit
            bit_valid_q   <= 1'b0;
            frame_first_q <= 1'b0;
            frame_last_q  <= 1'b0;
            state_q       <= StIdle;
          end else if (tick) begin
            ch_q          <= ch_next;
            frame_first_q <= 1'b0;
            if (ch_q == LastCh) begin
              // final channel: sel stays on it through DONE
              bit_valid_q  <= 1'b0;
              frame_last_q <= 1'b0;
              done_q       <= 1'b1;
              state_q      <= StDone;
            end else begin
              sel_q        <= lsb_q ? sel_q + SEL_W'(1) : sel_q - SEL_W'(1);
              frame_last_q <= (ch_next == LastCh);
            end
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.start_ready = (state_q == StIdle);
  assign bus.busy        = (state_q != StIdle);
  assign bus.data_q      = data_q;
  assign bus.sel         = sel_q;
  assign bus.bit_valid   = bit_valid_q;
  assign bus.frame_first = frame_first_q;
  assign bus.frame_last  = frame_last_q;
  assign bus.done        = done_q;

endmodule
